frog_game_ctrl: RTL and testbench
=================================

Name: frog_game_ctrl

Overview:
Game sequencer for the Frog game. It owns the frog's grid position, rate-limits hops from SW1-SW4, and starts, freezes and restarts the car-lane datapath. It consumes the collision flag and the frame sync, tracks lives and score, and steps through idle / play / hit / win / game-over. The pixel renderer reads player_col*32 and player_row*32; the car-movement logic is gated by car_run and cleared by respawn.

Parameters:
COLS, 20, grid columns (640/32)
ROWS, 15, grid rows (480/32)
START_COL, 9, respawn column
START_ROW, 13, respawn row (y=416)
GOAL_ROW, 0, row that scores a crossing
LIVES_INIT, 3, lives at game start (max 3, 2-bit counter)
MOVE_FRAMES, 8, frames of hop cooldown
HIT_FRAMES, 60, freeze length after a collision, in frames
WIN_FRAMES, 90, celebration length after a crossing, in frames

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
VGA_VS  in  1  vertical sync from the timing generator; its rising edge defines a frame
SW1  in  1  up / start
SW2  in  1  down
SW3  in  1  left
SW4  in  1  right
collision  in  1  level, frog overlaps a car (from collision detector)
player_col  out  5  frog column, 0..COLS-1
player_row  out  4  frog row, 0..ROWS-1
car_run  out  1  1 = car datapath may advance
respawn  out  1  one-cycle pulse: cars return to initial positions
lives  out  2  remaining lives
score  out  8  successful crossings, saturating
state  out  3  IDLE=0, PLAY=1, HIT=2, WIN=3, OVER=4
frame_tick  out  1  one-cycle pulse per VGA_VS rising edge

Behaviour:
- Reset values, applied on any cycle with RST=1 regardless of state:
  - state=IDLE, player_col=START_COL, player_row=START_ROW, lives=LIVES_INIT, score=0.
  - car_run=0, respawn=0, frame_tick=0, hop cooldown=0, frame timer=0.
  - Internal vs_prev=1 and sw1_prev=1, so no spurious tick or start occurs after reset.
- frame_tick: registered; asserted the cycle after VGA_VS is sampled high with vs_prev low. Exactly one cycle wide.
- All switches are sampled only on frame_tick cycles, which acts as debounce. sw1_prev updates on every tick.
- Start edge: SW1=1 at a tick with sw1_prev=0.
- IDLE:
  - car_run=0.
  - Start edge -> PLAY; lives<=LIVES_INIT, score<=0, position<=start, cooldown<=0, respawn pulse.
- PLAY, car_run=1, evaluated in this priority order:
  1. collision=1 on any cycle -> HIT; lives<=lives-1; timer<=HIT_FRAMES.
  2. Else if player_row==GOAL_ROW -> WIN; score<=score+1, saturating at 255; timer<=WIN_FRAMES.
  3. Else, on frame_tick:
     - If cooldown!=0, decrement it; no hop.
     - Else take the highest-priority asserted switch (SW1>SW2>SW3>SW4).
     - Blocked moves (up at row 0, down at ROWS-1, left at col 0, right at COLS-1) change nothing and do not load cooldown.
     - An accepted hop changes row/col by 1 and loads cooldown<=MOVE_FRAMES.
     - Minimum spacing between hops is therefore MOVE_FRAMES+1 ticks.
  - A hop into GOAL_ROW is registered first; WIN is entered on the following cycle unless collision is high then.
- HIT:
  - car_run=0; the timer decrements on each frame_tick.
  - When the timer reaches 0 at a tick:
    - lives==0 -> OVER.
    - Otherwise position<=start, cooldown<=0, respawn pulse, -> PLAY.
- WIN:
  - car_run=0; the timer decrements per tick.
  - At 0: position<=start, cooldown<=0, respawn pulse, -> PLAY. Lives are unchanged.
- OVER:
  - car_run=0; the position is held.
  - Start edge -> same actions as IDLE start.
- respawn is high exactly one cycle, in the cycle the state register becomes PLAY.
- collision is ignored outside PLAY.
- Switch inputs in HIT and WIN are ignored, but sw1_prev keeps tracking.
- The timer is 8 bits wide, so HIT_FRAMES and WIN_FRAMES must be at most 255. The cooldown counter is 4 bits wide, so MOVE_FRAMES must be at most 15.

Test Plan:
- Reset, then drive VGA_VS pulses with SW1 held high from reset -> no start (sw1_prev=1). Release SW1 for one tick, then press -> PLAY, respawn pulse once, car_run=1, lives=3, score=0, pos (9,13).
- In PLAY, hold SW3 for 30 ticks -> col 9->8 at the first tick, then a hop every 9 ticks (8,7,6,5). Hold SW4 at col 19 -> col stays 19 and cooldown is not loaded.
- Hold SW1 and SW2 together -> only up hops occur. Hop from row 1 to row 0 -> WIN next cycle, score=1, car_run=0; 90 ticks later PLAY at (9,13) with respawn pulse.
- Pulse collision for 1 cycle in PLAY -> HIT, lives 3->2, car_run=0. After 60 ticks -> PLAY at start. Repeat until lives=0 -> OVER, car_run stays 0, and position is held.
- Assert collision in the same cycle that row==0 is reached -> HIT, score unchanged. Assert RST mid-HIT -> next cycle IDLE with all reset values.
- Hold score at 255 and complete a crossing -> score stays 255. Hold VGA_VS constant high -> no further frame_tick.

Source files
------------

// File: rtl/frog_game_ctrl.sv
// frog_game_ctrl: Frog game sequencer; it owns the frog position, rate-limits hops,
// tracks lives and score, and starts, freezes and restarts the car lanes.
module frog_game_ctrl #(
  parameter int COLS        = 20,
  parameter int ROWS        = 15,
  parameter int START_COL   = 9,
  parameter int START_ROW   = 13,
  parameter int GOAL_ROW    = 0,
  parameter int LIVES_INIT  = 3,
  parameter int MOVE_FRAMES = 8,
  parameter int HIT_FRAMES  = 60,
  parameter int WIN_FRAMES  = 90
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       VGA_VS,
  input  logic       SW1,
  input  logic       SW2,
  input  logic       SW3,
  input  logic       SW4,
  input  logic       collision,
  output logic [4:0] player_col,
  output logic [3:0] player_row,
  output logic       car_run,
  output logic       respawn,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic [2:0] state,
  output logic       frame_tick
);
  localparam logic [4:0] SC = 5'(START_COL);
  localparam logic [4:0] LC = 5'(COLS - 1);
  localparam logic [3:0] SR = 4'(START_ROW);
  localparam logic [3:0] LR = 4'(ROWS - 1);
  localparam logic [3:0] GR = 4'(GOAL_ROW);
  localparam logic [3:0] MF = 4'(MOVE_FRAMES);
  localparam logic [7:0] HF = 8'(HIT_FRAMES);
  localparam logic [7:0] WF = 8'(WIN_FRAMES);
  localparam logic [1:0] LI = 2'(LIVES_INIT);
  typedef enum logic [2:0] {IDLE, PLAY, HIT, WIN, OVER} st_t;
  st_t        st;
  logic       vs_prev, sw1_prev, start, expire, go_play, up, dn, lf, rt;
  logic [3:0] cool;
  logic [7:0] timer;
  assign state   = st;
  assign start   = frame_tick && SW1 && !sw1_prev;
  assign expire  = frame_tick && timer <= 8'd1;
  assign go_play = ((st == IDLE || st == OVER) && start) || (st == WIN && expire) ||
                   (st == HIT && expire && lives != '0);
  // Only the highest-priority switch is considered; if its move is blocked nothing happens.
  assign up = SW1 && player_row != '0;
  assign dn = !SW1 && SW2 && player_row != LR;
  assign lf = !SW1 && !SW2 && SW3 && player_col != '0;
  assign rt = !SW1 && !SW2 && !SW3 && SW4 && player_col != LC;
  always_ff @(posedge CLK) begin
    if (RST) begin
      st         <= IDLE;
      player_col <= SC;
      player_row <= SR;
      lives      <= LI;
      score      <= '0;
      car_run    <= 1'b0;
      respawn    <= 1'b0;
      frame_tick <= 1'b0;
      cool       <= '0;
      timer      <= '0;
      vs_prev    <= 1'b1;
      sw1_prev   <= 1'b1;
    end else begin
      vs_prev    <= VGA_VS;
      frame_tick <= VGA_VS && !vs_prev;
      respawn    <= 1'b0;
      if (frame_tick) sw1_prev <= SW1;
      case (st)
        PLAY:
          if (collision) begin
            st      <= HIT;
            lives   <= lives - 2'd1;
            timer   <= HF;
            car_run <= 1'b0;
          end else if (player_row == GR) begin
            st      <= WIN;
            score   <= score + 8'(score != 8'hFF);
            timer   <= WF;
            car_run <= 1'b0;
          end else if (frame_tick) begin
            if (cool != '0) cool <= cool - 4'd1;
            else if (up || dn || lf || rt) begin
              player_row <= player_row + 4'(dn) - 4'(up);
              player_col <= player_col + 5'(rt) - 5'(lf);
              cool       <= MF;
            end
          end
        HIT, WIN:
          if (frame_tick) begin
            timer <= expire ? 8'd0 : timer - 8'd1;
            if (expire && st == HIT && lives == '0) st <= OVER;
          end
        IDLE, OVER: ;
        default: st <= IDLE;
      endcase
      // Every entry into PLAY shares the same restart actions; a fresh game also resets the tally.
      if (go_play) begin
        st         <= PLAY;
        car_run    <= 1'b1;
        respawn    <= 1'b1;
        player_col <= SC;
        player_row <= SR;
        cool       <= '0;
        if (st == IDLE || st == OVER) begin
          lives <= LI;
          score <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_frog_game_ctrl.sv
// tb_frog_game_ctrl: scoreboard bench for the Frog game sequencer.
module tb_frog_game_ctrl;
  logic       CLK = 0, RST = 1, VGA_VS = 0, SW1 = 1, SW2 = 0, SW3 = 0, SW4 = 0, collision = 0;
  logic       b_sw1 = 1;
  logic [4:0] player_col, b_col;
  logic [3:0] player_row, b_row;
  logic       car_run, respawn, frame_tick, b_car_run, b_respawn, b_frame_tick;
  logic [1:0] lives, b_lives;
  logic [7:0] score, b_score;
  logic [2:0] state, b_state;
  int         n_cmp = 0, n_bad = 0, rs_cnt = 0, ft_cnt = 0, rs_base = 0, ft_base = 0;
  typedef struct {string tag; int sel; logic [31:0] exp;} exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  frog_game_ctrl dut (
    .CLK(CLK), .RST(RST), .VGA_VS(VGA_VS), .SW1(SW1), .SW2(SW2), .SW3(SW3), .SW4(SW4),
    .collision(collision), .player_col(player_col), .player_row(player_row), .car_run(car_run),
    .respawn(respawn), .lives(lives), .score(score), .state(state), .frame_tick(frame_tick)
  );

  // Short crossings let the score reach saturation in a few hundred frames.
  frog_game_ctrl #(.START_ROW(1), .MOVE_FRAMES(0), .WIN_FRAMES(1)) dut_b (
    .CLK(CLK), .RST(RST), .VGA_VS(VGA_VS), .SW1(b_sw1), .SW2(1'b0), .SW3(1'b0), .SW4(1'b0),
    .collision(1'b0), .player_col(b_col), .player_row(b_row), .car_run(b_car_run),
    .respawn(b_respawn), .lives(b_lives), .score(b_score), .state(b_state), .frame_tick(b_frame_tick)
  );

  always @(negedge CLK) begin
    if (respawn) rs_cnt++;
    if (frame_tick) ft_cnt++;
  end

  function automatic logic [31:0] mk(input int st, input int lv, input int sc, input int r, input int c, input int cr);
    return {9'd0, st[2:0], lv[1:0], sc[7:0], r[3:0], c[4:0], cr[0]};
  endfunction

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: return mk(state, lives, score, player_row, player_col, car_run);
      1: return mk(b_state, b_lives, b_score, b_row, b_col, b_car_run);
      2: return rs_cnt - rs_base;
      3: return ft_cnt - ft_base;
      default: return {31'd0, frame_tick};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic want(input string tag, input int sel, input logic [31:0] v);
    sb.push_back('{tag, sel, v});
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic mark();
    rs_base = rs_cnt;
    ft_base = ft_cnt;
  endtask

  task automatic tick(input int n, input bit late = 0);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK) VGA_VS = 1;
      @(negedge CLK) VGA_VS = 0;
      @(negedge CLK) collision = late;
      @(negedge CLK) collision = 0;
    end
  endtask

  task automatic hit_pulse();
    @(negedge CLK) collision = 1;
    @(negedge CLK) collision = 0;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    RST = 0;
    mark();
    want("reset", 0, mk(0, 3, 0, 13, 9, 0));
    want("reset_tick", 4, 0);
    drain();
    tick(3);
    want("sw1_held_no_start", 0, mk(0, 3, 0, 13, 9, 0));
    want("tick_count", 3, 3);
    drain();
    SW1 = 0; tick(1); SW1 = 1; mark(); tick(1);
    want("start", 0, mk(1, 3, 0, 13, 9, 1));
    want("start_respawn", 2, 1);
    drain();
    SW1 = 0; SW3 = 1; tick(1);
    want("left_first", 0, mk(1, 3, 0, 13, 8, 1)); drain();
    tick(29);
    want("left_30", 0, mk(1, 3, 0, 13, 5, 1)); drain();
    SW3 = 0; SW4 = 1; tick(124);
    want("right_to_19", 0, mk(1, 3, 0, 13, 19, 1)); drain();
    tick(11);
    want("right_blocked", 0, mk(1, 3, 0, 13, 19, 1)); drain();
    SW4 = 0; SW3 = 1; tick(1);
    want("no_cool_after_block", 0, mk(1, 3, 0, 13, 18, 1)); drain();
    SW3 = 0; SW1 = 1; SW2 = 1; tick(9);
    want("up_priority", 0, mk(1, 3, 0, 12, 18, 1)); drain();
    tick(99);
    want("climb_row1", 0, mk(1, 3, 0, 1, 18, 1)); drain();
    mark(); tick(9);
    want("win", 0, mk(3, 3, 1, 0, 18, 0)); drain();
    SW1 = 0; SW2 = 0; tick(89);
    want("win_hold", 0, mk(3, 3, 1, 0, 18, 0)); drain();
    tick(1);
    want("win_done", 0, mk(1, 3, 1, 13, 9, 1));
    want("win_respawn", 2, 1);
    drain();
    SW3 = 1; tick(1); SW3 = 0;
    hit_pulse();
    want("hit1", 0, mk(2, 2, 1, 13, 8, 0)); drain();
    tick(59);
    want("hit1_hold", 0, mk(2, 2, 1, 13, 8, 0)); drain();
    tick(1);
    want("hit1_done", 0, mk(1, 2, 1, 13, 9, 1)); drain();
    hit_pulse(); tick(60);
    want("hit2_done", 0, mk(1, 1, 1, 13, 9, 1)); drain();
    SW2 = 1; tick(1); SW2 = 0;
    hit_pulse(); tick(60);
    want("over", 0, mk(4, 0, 1, 14, 9, 0)); drain();
    collision = 1; SW3 = 1; tick(3); collision = 0; SW3 = 0;
    want("over_hold", 0, mk(4, 0, 1, 14, 9, 0)); drain();
    SW1 = 1; mark(); tick(1);
    want("restart", 0, mk(1, 3, 0, 13, 9, 1));
    want("restart_respawn", 2, 1);
    drain();
    tick(108);
    want("climb2", 0, mk(1, 3, 0, 1, 9, 1)); drain();
    tick(1, 1);
    want("hit_at_goal", 0, mk(2, 2, 0, 0, 9, 0)); drain();
    tick(5);
    RST = 1;
    @(negedge CLK);
    want("rst_mid_hit", 0, mk(0, 3, 0, 13, 9, 0)); drain();
    RST = 0;
    tick(2);
    want("no_start_after_rst", 0, mk(0, 3, 0, 13, 9, 0)); drain();
    b_sw1 = 0; tick(1); b_sw1 = 1; tick(1);
    want("b_start", 1, mk(1, 3, 0, 1, 9, 1)); drain();
    tick(10);
    want("b_score5", 1, mk(1, 3, 5, 1, 9, 1)); drain();
    tick(510);
    want("b_score_sat", 1, mk(1, 3, 255, 1, 9, 1)); drain();
    mark();
    @(negedge CLK) VGA_VS = 1;
    repeat (20) @(negedge CLK);
    want("vs_high_one_tick", 3, 1);
    want("vs_high_tick_low", 4, 0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
